cbrt_arbiter: RTL and testbench

CBRT_ARBITER -- requirements
Module: cbrt_arbiter

---
 rtl/cbrt_arbiter_pkg.sv | 14 +
 rtl/cbrt_arbiter_rr_pick.sv | 29 ++
 rtl/cbrt_arbiter.sv | 134 +++++++++++++
 tb/tb_cbrt_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbrt_arbiter_pkg.sv
// Shared state encoding and parameter defaults for the cube-root request arbiter.
package cbrt_arbiter_pkg;

  localparam int unsigned NReqDefault    = 4;
  localparam int unsigned TimeoutDefault = 1023;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/cbrt_arbiter_rr_pick.sv
// Round-robin search: first set request bit at or after ptr, wrapping modulo N_REQ.
module cbrt_arbiter_rr_pick
  import cbrt_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned IdxW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic             grant_valid,
  output logic [IdxW-1:0]  grant_idx
);

  logic [IdxW-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IdxW'((32'(ptr) + k) % N_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cbrt_arbiter.sv
// Round-robin arbiter sharing one external cube-root core among N_REQ requesters,
// with a busy-cycle timeout that aborts a stuck core operation.
module cbrt_arbiter
  import cbrt_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = NReqDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [2:0]         resp_result,
  output logic               resp_err,
  output logic [7:0]         core_x,
  output logic               core_start,
  input  logic               core_busy,
  input  logic [2:0]         core_result,
  output logic               err_sticky
);

  localparam int unsigned     IdxW   = $clog2(N_REQ);
  localparam int unsigned     CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] id_q, id_d;
  logic [7:0]      x_q, x_d;
  logic [2:0]      res_q, res_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            grant_valid;
  logic [IdxW-1:0] grant_idx;

  cbrt_arbiter_rr_pick #(
    .N_REQ(N_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    res_d       = res_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    resp_valid  = '0;
    resp_result = '0;
    resp_err    = 1'b0;
    core_x      = '0;
    core_start  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gate with rst so req_ready stays low while reset is held.
        if (rst && grant_valid) begin
          req_ready[grant_idx] = 1'b1;
          x_d                  = req_x[{grant_idx, 3'b000} +: 8];
          id_d                 = grant_idx;
          state_d              = StLaunch;
        end
      end
      StLaunch: begin
        core_start = 1'b1;
        core_x     = x_q;
        cnt_d      = '0;
        state_d    = StWait;
      end
      StWait: begin
        core_x = x_q;
        if (!core_busy) begin
          res_d   = core_result;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntMax) begin
            res_d    = '0;
            err_d    = 1'b1;
            sticky_d = 1'b1;
            state_d  = StResp;
          end
        end
      end
      StResp: begin
        resp_valid[id_q] = 1'b1;
        resp_result      = res_q;
        resp_err         = err_q;
        // Served requester drops to lowest priority for the next search.
        rr_ptr_d         = (id_q == IdxW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        err_d            = 1'b0;
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_sticky = sticky_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      x_q      <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      x_q      <= x_d;
      res_q    <= res_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cbrt_arbiter.sv
// Scoreboard bench for cbrt_arbiter: directed scenarios, then randomized requesters
// against a transaction-level round-robin model and a behavioural cube-root core.
module tb_cbrt_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_x;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [2:0]     resp_result;
  logic           resp_err;
  logic [7:0]     core_x;
  logic           core_start;
  logic           core_busy;
  logic [2:0]     core_result;
  logic           err_sticky;

  cbrt_arbiter #(
    .N_REQ  (N),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_result(resp_result),
    .resp_err   (resp_err),
    .core_x     (core_x),
    .core_start (core_start),
    .core_busy  (core_busy),
    .core_result(core_result),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int cbrt8(int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int rr_expect(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Behavioural core: busy for cur_d cycles after start, then presents cbrt(x).
  int pending = 0;
  int cur_d   = 0;
  int force_d = -1;
  bit stuck   = 1'b0;

  initial begin
    core_busy   = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        pending   = 0;
        core_busy = 1'b0;
      end else if (core_start) begin
        if (force_d >= 0) cur_d = force_d;
        else if (stuck) cur_d = 1000;
        else cur_d = $urandom_range(0, 14);
        pending     = cur_d;
        core_result = 3'(cbrt8(int'(core_x)));
        core_busy   = 1'b0;
      end else if (pending > 0) begin
        core_busy = 1'b1;
        pending--;
      end else begin
        core_busy = 1'b0;
      end
    end
  end

  // Reference model and scoreboard
  typedef struct {
    int res;
    int err;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   res_log[$];
  bit   m_inflight = 1'b0;
  int   m_g, m_id, m_x;
  int   m_ptr = 0;
  bit   m_sticky = 1'b0;
  int   cyc = 0;

  initial begin
    int         lat, w;
    logic [N-1:0] e_ready, e_resp;
    logic [7:0] e_x;
    bit         e_start;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_outputs", {req_ready, resp_valid, resp_result, resp_err, core_x, core_start,
                              err_sticky}, 0);
        m_inflight = 1'b0;
        m_ptr      = 0;
        m_sticky   = 1'b0;
        sb.delete();
      end else begin
        cyc++;
        e_ready = '0;
        e_resp  = '0;
        e_x     = '0;
        e_start = 1'b0;
        w       = -1;
        lat     = (cur_d >= TO) ? 2 + TO : 3 + cur_d;
        if (!m_inflight) begin
          w = rr_expect(req_valid, m_ptr);
          if (w >= 0) e_ready[w] = 1'b1;
        end else begin
          e_start = (cyc == m_g + 1);
          if (cyc > m_g && cyc < m_g + lat) e_x = 8'(m_x);
          if (cyc == m_g + lat) e_resp[m_id] = 1'b1;
        end
        for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
        if (resp_valid != 0) res_log.push_back(int'(resp_result));
        chk("req_ready", req_ready, e_ready);
        chk("core_start", core_start, e_start);
        chk("core_x", core_x, e_x);
        chk("resp_valid", resp_valid, e_resp);
        if (e_resp != 0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk("resp_result", resp_result, e.res);
            chk("resp_err", resp_err, e.err);
            if (e.err != 0) m_sticky = 1'b1;
          end
          m_inflight = 1'b0;
          m_ptr      = (m_id + 1) % N;
        end else begin
          chk("resp_idle", {resp_result, resp_err}, 0);
        end
        chk("err_sticky", err_sticky, m_sticky);
        if (w >= 0) begin
          m_inflight = 1'b1;
          m_g        = cyc;
          m_id       = w;
          m_x        = int'(req_x[8*w +: 8]);
          e.res      = stuck ? 0 : cbrt8(m_x);
          e.err      = stuck ? 1 : 0;
          sb.push_back(e);
        end
      end
    end
  end

  // Requester side
  logic [N-1:0] hold = '0;
  logic [7:0]   hold_x [N];

  task automatic apply();
    req_valid = hold;
    for (int i = 0; i < N; i++) req_x[8*i +: 8] = hold_x[i];
  endtask

  task automatic step();
    logic [N-1:0] g;
    @(negedge clk);
    g = req_ready;
    @(posedge clk);
    #1;
    hold = hold & ~g;
    apply();
  endtask

  task automatic issue(int i, int x);
    hold[i]   = 1'b1;
    hold_x[i] = 8'(x);
    apply();
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (!(hold == 0 && !m_inflight && sb.size() == 0) && n < budget) begin
      step();
      n++;
    end
    chk(name, (hold == 0 && !m_inflight && sb.size() == 0), 1);
    step();
  endtask

  task automatic wait_grant(string name, int i, int budget);
    int n = 0;
    while (hold[i] && n < budget) begin
      step();
      n++;
    end
    chk(name, hold[i], 0);
  endtask

  function automatic void check_log(string name, int q[$], int n, int e0, int e1, int e2,
                                    int e3);
    int e[4];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    e[3] = e3;
    chk({name, "_len"}, q.size(), n);
    for (int k = 0; k < n && k < q.size(); k++) chk(name, q[k], e[k]);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < N; i++) hold_x[i] = '0;
    apply();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // All four at once from rr_ptr=0
    grant_log.delete();
    res_log.delete();
    issue(0, 8);
    issue(1, 27);
    issue(2, 64);
    issue(3, 125);
    wait_idle("simul_done", 200);
    check_log("simul_order", grant_log, 4, 0, 1, 2, 3);
    check_log("simul_results", res_log, 4, 2, 3, 4, 5);

    // Single request
    grant_log.delete();
    res_log.delete();
    issue(2, 27);
    wait_idle("single_done", 100);
    check_log("single_order", grant_log, 1, 2, 0, 0, 0);
    check_log("single_results", res_log, 1, 3, 0, 0, 0);

    // Fairness: requester 1 re-requests at once, requester 3 arrives after first grant
    grant_log.delete();
    res_log.delete();
    issue(1, 216);
    wait_grant("fair_first_grant", 1, 50);
    issue(3, 64);
    issue(1, 216);
    wait_idle("fair_done", 200);
    check_log("fair_order", grant_log, 3, 1, 3, 1, 0);
    check_log("fair_results", res_log, 3, 6, 4, 6, 0);

    // Longest busy time that still completes normally
    res_log.delete();
    force_d = TO - 1;
    issue(2, 200);
    wait_idle("near_timeout_done", 100);
    force_d = -1;
    check_log("near_timeout_result", res_log, 1, 5, 0, 0, 0);
    chk("sticky_clear_before_timeout", err_sticky, 0);

    // Stuck core aborts after TO busy cycles
    res_log.delete();
    stuck = 1'b1;
    issue(0, 100);
    wait_idle("timeout_done", 100);
    stuck = 1'b0;
    check_log("timeout_result", res_log, 1, 0, 0, 0, 0);
    chk("sticky_after_timeout", err_sticky, 1);
    issue(1, 27);
    wait_idle("post_timeout_done", 100);
    chk("sticky_holds", err_sticky, 1);

    // Reset in the middle of WAIT drops the request silently
    grant_log.delete();
    res_log.delete();
    force_d = 10;
    issue(2, 125);
    wait_grant("rst_grant", 2, 50);
    repeat (4) step();
    rst = 1'b0;
    repeat (3) step();
    chk("sticky_cleared_by_reset", err_sticky, 0);
    force_d = -1;
    issue(0, 8);
    rst = 1'b1;
    wait_idle("post_reset_done", 100);
    check_log("reset_order", grant_log, 2, 2, 0, 0, 0);
    check_log("reset_results", res_log, 1, 2, 0, 0, 0);

    // Randomized requesters with occasional withdrawal before grant
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            hold[i]   = 1'b1;
            hold_x[i] = 8'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          hold[i] = 1'b0;
        end
      end
      apply();
      step();
    end
    hold = '0;
    apply();
    wait_idle("random_drain", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
